// File: rtl/rf_dump_pkg.sv
// Shared types for the register-file dump serializer: FSM states, byte geometry
// and the per-register header byte format.
package rf_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } rf_dump_state_e;

    localparam int RF_DWIDTH_DEF = 32;
    localparam int BYTES_PER_REG = RF_DWIDTH_DEF / 8;

    typedef logic [7:0] hdr_byte_t;

    function automatic int bytes_per_reg(input int dwidth);
        return dwidth / 8;
    endfunction

    // Header byte: register index zero-extended to 8 bits.
    function automatic hdr_byte_t hdr_byte(input logic [7:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/rf_dump_serializer.sv
// Walks the register file through a debug read port and streams each register
// little-endian as bytes to the TX interface. RF_DUMP_HDR_EN adds an index header byte.
module rf_dump_serializer
    import rf_dump_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int NREGS  = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              i_dbg_run,
    input  logic              i_start,
    output logic [AWIDTH-1:0] o_ra,
    input  logic [DWIDTH-1:0] i_rd,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done,
    output rf_dump_state_e    o_dbg_state
);

    localparam int BPR = bytes_per_reg(DWIDTH);
`ifdef RF_DUMP_HDR_EN
    localparam int SLOTS = BPR + 1;
`else
    localparam int SLOTS = BPR;
`endif
    localparam int CW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [CW-1:0]     LAST_SLOT = CW'(SLOTS - 1);
    localparam logic [AWIDTH-1:0] LAST_IDX  = AWIDTH'(NREGS - 1);

    rf_dump_state_e    state_q, state_d;
    logic [AWIDTH-1:0] idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] shift_q, shift_d;
    logic              abort_q, abort_d;

    logic abort_now;
    logic xfer;
    logic hdr_slot;

`ifdef RF_DUMP_HDR_EN
    assign hdr_slot = (cnt_q == '0);
`else
    assign hdr_slot = 1'b0;
`endif

    // A halt request seen this cycle counts immediately, not only from the next one.
    assign abort_now = (state_q != ST_IDLE) && (abort_q || i_dbg_run);
    assign xfer      = (state_q == ST_SEND) && i_tx_ready;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        abort_d = abort_q;
        if (state_q != ST_IDLE && i_dbg_run) begin
            abort_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_dbg_run) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort_now) begin
                    state_d = ST_IDLE;
                end else begin
                    shift_d = i_rd;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // Everything presented on the TX side only moves on a completed transfer.
                if (xfer) begin
                    if (!hdr_slot) begin
                        shift_d = shift_q >> 8;
                    end
                    if (abort_now) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == LAST_SLOT) begin
                        cnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + AWIDTH'(1);
                            state_d = ST_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy      = (state_q == ST_LOAD) || (state_q == ST_SEND);
        o_done      = (state_q == ST_DONE);
        o_tx_valid  = (state_q == ST_SEND);
        o_ra        = o_busy ? idx_q : '0;
        o_tx_data   = 8'h00;
        o_dbg_state = state_q;
        if (state_q == ST_SEND) begin
            o_tx_data = hdr_slot ? hdr_byte(8'(idx_q)) : shift_q[7:0];
        end
    end

endmodule

// File: tb/tb_rf_dump_serializer.sv
// Bench for rf_dump_serializer: scenario table plus hand-written abort/reset
// sequences; define RF_DUMP_HDR_EN for both files to exercise the header build.
module tb_rf_dump_serializer;
    import rf_dump_pkg::*;

`ifdef RF_DUMP_HDR_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif
    localparam int NR        = 32;
    localparam int RB        = 4 + HB;
    localparam int TOTAL     = NR * RB;
    localparam int FULL_CYC  = NR * (1 + RB) + 1;
    localparam int BUDGET    = 3000;

    logic           CLK = 1'b0;
    logic           RSTn;
    logic           i_dbg_run;
    logic           i_start;
    logic [4:0]     o_ra;
    logic [31:0]    i_rd;
    logic [7:0]     o_tx_data;
    logic           o_tx_valid;
    logic           i_tx_ready;
    logic           o_busy;
    logic           o_done;
    rf_dump_state_e o_dbg_state;

    logic [31:0] rf [0:NR-1];
    logic [7:0]  got [0:255];
    logic [7:0]  exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int nbytes, done_cycle, last_xfer;
    bit saw_done;

    always #5 CLK = ~CLK;

    assign i_rd = rf[o_ra];

    rf_dump_serializer #(.DWIDTH(32), .AWIDTH(5), .NREGS(NR)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .i_dbg_run  (i_dbg_run),
        .i_start    (i_start),
        .o_ra       (o_ra),
        .i_rd       (i_rd),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_dbg_state(o_dbg_state)
    );

    typedef struct {
        int          ready_pct;
        logic [31:0] x5;
        logic [31:0] x31;
        int          exp_done;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int off(input int r);
        return r * RB + HB;
    endfunction

    // Expected byte stream built straight from the bench's register file copy.
    task automatic build_expected();
        exp_q.delete();
        for (int r = 0; r < NR; r++) begin
            if (HB == 1) exp_q.push_back(8'(r));
            for (int k = 0; k < 4; k++) exp_q.push_back(rf[r][8*k +: 8]);
        end
    endtask

    task automatic run_dump(input int ready_pct, input int abort_after, input int rst_after);
        int   cycle;
        bit   prev_stall;
        logic [7:0] prev_data;
        logic [7:0] e;
        bit   ended;
        build_expected();
        nbytes = 0; done_cycle = -1; last_xfer = -1; saw_done = 0;
        prev_stall = 0; prev_data = '0; ended = 0;
        @(negedge CLK); i_start = 1'b1;
        @(posedge CLK);
        @(negedge CLK); i_start = 1'b0;
        cycle = 1;
        chk("busy_in_load", {31'd0, o_busy}, 32'd1);
        chk("valid_in_load", {31'd0, o_tx_valid}, 32'd0);
        while (cycle < BUDGET && !ended) begin
            if (o_done) begin
                saw_done = 1; done_cycle = cycle; ended = 1;
            end else if (!o_busy) begin
                ended = 1;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", {31'd0, o_tx_valid}, 32'd1);
                    chk("stall_data", {24'd0, o_tx_data}, {24'd0, prev_data});
                end
                if (o_tx_valid) chk("ra_in_send", {27'd0, o_ra}, nbytes / RB);
                if (abort_after >= 0 && nbytes == abort_after) i_dbg_run = 1'b1;
                if (rst_after >= 0 && nbytes == rst_after && o_tx_valid) begin
                    RSTn = 1'b0; i_tx_ready = 1'b0;
                    @(posedge CLK); #1;
                    chk("rst_valid", {31'd0, o_tx_valid}, 32'd0);
                    chk("rst_busy", {31'd0, o_busy}, 32'd0);
                    chk("rst_ra", {27'd0, o_ra}, 32'd0);
                    @(negedge CLK); RSTn = 1'b1;
                    ended = 1;
                end else begin
                    i_tx_ready = ($urandom_range(99) < ready_pct);
                    if (o_tx_valid && i_tx_ready) begin
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                        chk("byte", {24'd0, o_tx_data}, {24'd0, e});
                        if (nbytes < 256) got[nbytes] = o_tx_data;
                        nbytes++; last_xfer = cycle; prev_stall = 0;
                    end else begin
                        prev_stall = o_tx_valid; prev_data = o_tx_data;
                    end
                    @(posedge CLK); @(negedge CLK);
                    cycle++;
                end
            end
        end
        if (!ended) chk("dump_timeout", 32'd1, 32'd0);
        i_tx_ready = 1'b0;
    endtask

    initial begin
        RSTn = 1'b0; i_dbg_run = 1'b0; i_start = 1'b0; i_tx_ready = 1'b0;
        for (int r = 0; r < NR; r++) rf[r] = '0;
        rf[2] = 32'h0000_0F00;
        rf[3] = 32'h0000_0100;
        repeat (3) @(posedge CLK);
        @(negedge CLK); RSTn = 1'b1;

        chk("reset_ra", {27'd0, o_ra}, 32'd0);
        chk("reset_data", {24'd0, o_tx_data}, 32'd0);
        chk("reset_valid", {31'd0, o_tx_valid}, 32'd0);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_done", {31'd0, o_done}, 32'd0);

        vecs[0] = '{100, 32'h0000_0000, 32'h0000_0000, FULL_CYC};
        vecs[1] = '{100, 32'hDEAD_BEEF, 32'h1234_5678, FULL_CYC};
        vecs[2] = '{40,  32'hA5A5_5A5A, 32'h0102_0304, -1};
        vecs[3] = '{70,  $urandom,      $urandom,      -1};

        for (int v = 0; v < 4; v++) begin
            rf[5]  = vecs[v].x5;
            rf[31] = vecs[v].x31;
            run_dump(vecs[v].ready_pct, -1, -1);
            chk("saw_done", {31'd0, saw_done}, 32'd1);
            chk("byte_total", nbytes, TOTAL);
            chk("queue_empty", exp_q.size(), 32'd0);
            chk("done_after_last", done_cycle, last_xfer + 1);
            chk("done_not_busy", {31'd0, o_busy}, 32'd0);
            if (vecs[v].exp_done >= 0) chk("done_cycle", done_cycle, vecs[v].exp_done);
            @(negedge CLK);
            chk("done_one_cycle", {31'd0, o_done}, 32'd0);
            if (v == 1) begin
                chk("x2_bytes", {got[off(2)+3], got[off(2)+2], got[off(2)+1], got[off(2)]}, 32'h0000_0F00);
                chk("x3_bytes", {got[off(3)+3], got[off(3)+2], got[off(3)+1], got[off(3)]}, 32'h0000_0100);
                chk("x5_b0", {24'd0, got[off(5)]},   32'hEF);
                chk("x5_b3", {24'd0, got[off(5)+3]}, 32'hDE);
                chk("x31_b0", {24'd0, got[off(31)]},   32'h78);
                chk("x31_b3", {24'd0, got[off(31)+3]}, 32'h12);
`ifdef RF_DUMP_HDR_EN
                chk("hdr_byte0", {24'd0, got[0]},   32'h00);
                chk("hdr_byte5", {24'd0, got[5]},   32'h01);
                chk("hdr_byte155", {24'd0, got[155]}, 32'h1F);
`else
                chk("byte8_x2", {24'd0, got[8]},   32'h00);
                chk("byte9_x2", {24'd0, got[9]},   32'h0F);
                chk("byte20_x5", {24'd0, got[20]}, 32'hEF);
                chk("byte127_x31", {24'd0, got[127]}, 32'h12);
`endif
            end
        end

        // Start while the core runs must be ignored.
        @(negedge CLK); i_dbg_run = 1'b1; i_start = 1'b1;
        @(negedge CLK); i_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("run_start_busy", {31'd0, o_busy}, 32'd0);
            chk("run_start_valid", {31'd0, o_tx_valid}, 32'd0);
            @(negedge CLK);
        end
        i_dbg_run = 1'b0;

        // Halt during register 10: the presented byte completes, then idle, no done.
        run_dump(60, 10 * RB + 2, -1);
        chk("abort_bytes", nbytes, 10 * RB + 3);
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            chk("abort_idle_done", {31'd0, o_done}, 32'd0);
            chk("abort_idle_busy", {31'd0, o_busy}, 32'd0);
            @(negedge CLK);
        end
        i_dbg_run = 1'b0;

        // Reset mid-SEND, then a fresh dump must start again from x0.
        run_dump(100, -1, 50);
        chk("rst_bytes", nbytes, 50);
        run_dump(80, -1, -1);
        chk("restart_done", {31'd0, saw_done}, 32'd1);
        chk("restart_total", nbytes, TOTAL);
        chk("restart_first", {24'd0, got[HB]}, {24'd0, rf[0][7:0]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
